// File: rtl/bcd2bin_if.sv
// Register-bus side of the BCD-to-binary converter: request, operand and result/status.
interface bcd2bin_if #(
    parameter int unsigned BCD_N = 4,
    parameter int unsigned BIN_N = 14
);
    localparam int unsigned W  = BIN_N - 1;
    localparam int unsigned BW = 4 * BCD_N;

    logic          start;
    logic          sign;
    logic [BW-1:0] bcd;
    logic          ready;
    logic          done_tick;
    logic [W-1:0]  bin;
    logic          bin_sign;
    logic          err;
    logic          ovf;

    modport master (
        output start, sign, bcd,
        input  ready, done_tick, bin, bin_sign, err, ovf
    );

    modport slave (
        input  start, sign, bcd,
        output ready, done_tick, bin, bin_sign, err, ovf
    );
endinterface

// File: rtl/bcd2bin.sv
// Sequential signed-BCD to sign-magnitude binary converter (reverse double-dabble,
// one bit per cycle) with invalid-digit and saturating overflow reporting.
module bcd2bin #(
    parameter int unsigned BCD_N = 4,
    parameter int unsigned BIN_N = 14
) (
    input  logic       clk,
    input  logic       reset,
    bcd2bin_if.slave   bus
);
    localparam int unsigned W  = BIN_N - 1;
    localparam int unsigned BW = 4 * BCD_N;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_OP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          sign_q, sign_d;
    logic [CW-1:0] n_q, n_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [W-1:0]  bin_q, bin_d;
    logic          bin_sign_q, bin_sign_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    logic             digit_bad_c;
    logic [BW+W-1:0]  shifted_c;
    logic [BW-1:0]    bcd_adj_c;

    // Any incoming nibble above 9 marks the operand as invalid.
    always_comb begin
        digit_bad_c = 1'b0;
        for (int unsigned i = 0; i < BCD_N; i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) digit_bad_c = 1'b1;
        end
    end

    // One reverse double-dabble step: shift right, then correct nibbles >= 8 by -3.
    always_comb begin
        shifted_c = {bcd_q, acc_q} >> 1;
        for (int unsigned i = 0; i < BCD_N; i++) begin
            bcd_adj_c[4*i +: 4] = shifted_c[W + 4*i + 3] ? (shifted_c[W + 4*i +: 4] - 4'd3)
                                                          : shifted_c[W + 4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bcd_q      <= '0;
            acc_q      <= '0;
            sign_q     <= 1'b0;
            n_q        <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            bin_q      <= '0;
            bin_sign_q <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            acc_q      <= acc_d;
            sign_q     <= sign_d;
            n_q        <= n_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            bin_q      <= bin_d;
            bin_sign_q <= bin_sign_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        acc_d      = acc_q;
        sign_d     = sign_q;
        n_d        = n_q;
        done_d     = 1'b0;
        bin_d      = bin_q;
        bin_sign_d = bin_sign_q;
        err_d      = err_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bcd_d  = bus.bcd;
                    sign_d = bus.sign;
                    acc_d  = '0;
                    n_d    = CW'(W - 1);
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (digit_bad_c) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        err_d      = 1'b1;
                        bin_d      = '0;
                        bin_sign_d = 1'b0;
                    end else begin
                        state_d = S_OP;
                    end
                end
            end
            S_OP: begin
                bcd_d = bcd_adj_c;
                acc_d = shifted_c[W-1:0];
                if (n_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    // Leftover decimal content means the value did not fit in W bits.
                    if (bcd_adj_c != '0) begin
                        ovf_d      = 1'b1;
                        bin_d      = '1;
                        bin_sign_d = sign_q;
                    end else begin
                        bin_d      = shifted_c[W-1:0];
                        bin_sign_d = sign_q && (shifted_c[W-1:0] != '0);
                    end
                end else begin
                    n_d = n_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign bus.ready     = ready_q;
    assign bus.done_tick = done_q;
    assign bus.bin       = bin_q;
    assign bus.bin_sign  = bin_sign_q;
    assign bus.err       = err_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/bcd2bin.md
# bcd2bin

Sequential BCD-to-binary converter, the inverse of the `bin2bcd` block. It accepts a signed, packed BCD value of `BCD_N` digits and produces a sign-magnitude binary result using reverse double-dabble (shift right, then subtract 3). It sits on the MCU register bus next to `bin2bcd`, converting decimal values such as UART-entered set points into binary for the timer, PWM and display blocks. Its status outputs are shaped like those of `bin2bcd`, so the existing `tick_counter` can count `done_tick`.

## Interface

Parameters:
- `BCD_N`, default 4: number of BCD digits in.
- `BIN_N`, default 14: total binary width including sign; the magnitude is `W = BIN_N-1` bits.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset; one clock domain.
- `start`  in  1  request a conversion; sampled only while `ready` = 1.
- `sign`  in  1  input sign (1 = negative); latched with `bcd`.
- `bcd`  in  4*BCD_N  packed BCD digits, most significant digit in the MSBs.
- `ready`  out  1  idle and able to accept `start`.
- `done_tick`  out  1  one-cycle pulse when a result is valid.
- `bin`  out  W  magnitude result.
- `bin_sign`  out  1  result sign.
- `err`  out  1  an input digit was greater than 9.
- `ovf`  out  1  the input magnitude exceeds 2^W-1.

## Operation

States:
- **IDLE**
  - `ready` = 1.
  - On `start`: latch `bcd` into `bcd_reg` and `sign` into `sign_reg`, clear `bin_reg`, set counter `n` = W-1.
  - If any nibble of `bcd` is greater than 9, go to DONE with `err` = 1. Otherwise go to OP.
- **OP**, once per cycle:
  - Shift `{bcd_reg, bin_reg}` right by 1.
  - Then subtract 3 from every BCD nibble of the shifted value that is ≥ 8.
  - Register the result.
  - If `n` = 0, go to DONE; otherwise decrement `n`.
- **DONE**
  - `done_tick` = 1 for this single cycle; next state is IDLE.

Result rules, applied on entry to DONE and held until the next accepted `start`:
- **Overflow:** if `bcd_reg` ≠ 0 after the last OP iteration, `ovf` = 1 and `bin` = 2^W-1 (saturated).
- **Error:** if `err` = 1, then `bin` = 0, `bin_sign` = 0 and `ovf` = 0.
- **Sign:** `bin_sign` = `sign_reg`, except that it is forced to 0 when `bin` = 0 (no negative zero).
- **Clearing flags:** `err` and `ovf` clear when the next `start` is accepted.

Boundary behaviour:
- `start` while in OP or DONE is ignored; there is no queueing.
- `bcd` and `sign` changing after `start` is accepted have no effect.
- Reset asserted mid-conversion aborts immediately. The block returns to IDLE and drops the partial result.
- Reset values: state = IDLE, `ready` = 1, `done_tick` = 0, `bin` = 0, `bin_sign` = 0, `err` = 0, `ovf` = 0, `n` = 0.
- Counter `n` is $clog2(W) bits wide. The nibble subtract is 4-bit and cannot underflow, because it only applies when the nibble is ≥ 8.

## Timing

- `ready` is a Moore output (state == IDLE) and is combinational from state only.
- **Valid conversion:**
  - `start` is sampled at edge E0.
  - OP occupies edges E1..EW.
  - `done_tick` is high for exactly the cycle after EW.
  - `ready` is high again from edge EW+1.
  - Start-to-result latency is W+1 cycles: 14 cycles at the defaults.
- **Invalid digit:** `done_tick` is high in the cycle after E0 (latency 1).
- **Back-to-back:** `start` held high continuously yields one conversion every W+2 cycles.
- **Output stability:** `bin`, `bin_sign`, `err` and `ovf` are registered and glitch-free. They are valid during `done_tick` and stable until the edge that accepts the next `start`.
- **Reset:** deassertion is synchronised externally; the block is ready on the first edge after deassertion.

## Test plan

- `bcd` = 16'h1234, `sign` = 0, one-cycle `start`:
  - `done_tick` 14 cycles after the start edge.
  - `bin` = 13'd1234 (0x4D2), `bin_sign` = 0, `err` = 0, `ovf` = 0.
  - `ready` low for 14 cycles.
- `bcd` = 16'h8191, `sign` = 1:
  - `bin` = 8191, `bin_sign` = 1, `ovf` = 0.
- `bcd` = 16'h8192, then `bcd` = 16'h9999:
  - `ovf` = 1 and `bin` = 8191 for both.
  - Then `bcd` = 16'h0000 with `sign` = 1 gives `bin` = 0, `bin_sign` = 0.
- `bcd` = 16'h12A4:
  - `done_tick` 1 cycle after the start edge, `err` = 1, `bin` = 0.
  - A following valid `start` clears `err`.
- **Busy and reset:**
  - Pulse `start` with `bcd` = 16'h0042 during a 16'h0007 conversion: the second request is ignored and the result is 7.
  - Assert `reset` 5 cycles into a conversion: all outputs go to their reset values immediately, with no `done_tick`.
- **Random regression:** 1000 random valid and invalid inputs checked against a decimal reference model. `done_tick` count must equal the number of accepted starts.
